// File: rtl/button_select_pkg.sv
// Shared constants and helpers for the front-panel selection controller.
// Holds the default parameter values used by button_select_ctrl, the step
// direction enum, and the field-index width helper used to size the index
// ports (focus, update_field and the index part of the button code).
package button_select_pkg;

  localparam int N_FIELDS_DEFAULT = 4;
  localparam int VAL_W_DEFAULT    = 3;
  localparam int DEBOUNCE_DEFAULT = 480;

  // Field 0 lives in the LSBs: field0=4, field1=1, field2=2, field3=0.
  localparam logic [11:0] RESET_VALS_DEFAULT = {3'd0, 3'd2, 3'd1, 3'd4};

  typedef enum logic [1:0] {
    STEP_NONE,
    STEP_INC,
    STEP_DEC
  } step_dir_e;

  // Width of a field index; never narrower than one bit.
  function automatic int field_idx_width(input int n_fields);
    return (n_fields <= 2) ? 1 : $clog2(n_fields);
  endfunction

endpackage

// File: rtl/debounce_sync.sv
// Two-flop synchroniser followed by a stability debouncer.
// A new synchronised value becomes the candidate and restarts the counter;
// once the candidate has been held for CYCLES cycles and differs from the
// accepted value, it is accepted and a one-cycle commit pulse is raised.
//
// Ports:
//   clk_48   in   system clock
//   reset_n  in   asynchronous active-low reset (clears every register)
//   raw_in   in   [W] raw asynchronous input
//   stable   out  [W] debounced, accepted value
//   commit   out  one-cycle pulse in the cycle stable takes a new value
module debounce_sync #(
  parameter int W      = 1,
  parameter int CYCLES = 480
) (
  input  logic         clk_48,
  input  logic         reset_n,
  input  logic [W-1:0] raw_in,
  output logic [W-1:0] stable,
  output logic         commit
);

  localparam int              CNT_W    = $clog2(CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLES - 1);

  logic [W-1:0]     sync_q1;
  logic [W-1:0]     sync_q2;
  logic [W-1:0]     candidate;
  logic [CNT_W-1:0] counter;

  // The counter parks at CNT_LAST so a held value commits exactly once;
  // only a change of the synchronised input restarts it.
  always_ff @(posedge clk_48 or negedge reset_n) begin
    if (!reset_n) begin
      sync_q1   <= '0;
      sync_q2   <= '0;
      candidate <= '0;
      stable    <= '0;
      counter   <= '0;
      commit    <= 1'b0;
    end else begin
      sync_q1 <= raw_in;
      sync_q2 <= sync_q1;
      commit  <= 1'b0;
      if (sync_q2 != candidate) begin
        candidate <= sync_q2;
        counter   <= '0;
      end else if (counter != CNT_LAST) begin
        counter <= counter + CNT_W'(1);
      end else if (candidate != stable) begin
        stable <= candidate;
        commit <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/button_select_ctrl.sv
// Front-panel selection controller. Turns debounced button codes and
// up/down step buttons into N_FIELDS selection values feeding the filter
// coefficient muxes, with an update strobe for coefficient reload.
//
// Ports:
//   clk_48        in   system clock
//   reset_n       in   asynchronous active-low reset
//   code_in       in   [CODE_W] raw button code {field index, value}
//   step_up       in   raw increment button, active-high
//   step_down     in   raw decrement button, active-high
//   field_vals    out  [N_FIELDS*VAL_W] field i at [i*VAL_W +: VAL_W]
//   focus         out  [IDX_W] field last written by a button code
//   update        out  one-cycle pulse when a field value changes
//   update_field  out  [IDX_W] changed field, valid while update is high
module button_select_ctrl
  import button_select_pkg::*;
#(
  parameter int                          N_FIELDS   = N_FIELDS_DEFAULT,
  parameter int                          VAL_W      = VAL_W_DEFAULT,
  parameter int                          DEBOUNCE   = DEBOUNCE_DEFAULT,
  parameter int                          WRAP       = 0,
  parameter logic [N_FIELDS*VAL_W-1:0]   RESET_VALS = RESET_VALS_DEFAULT,
  localparam int                         IDX_W      = field_idx_width(N_FIELDS),
  localparam int                         CODE_W     = IDX_W + VAL_W
) (
  input  logic                        clk_48,
  input  logic                        reset_n,
  input  logic [CODE_W-1:0]           code_in,
  input  logic                        step_up,
  input  logic                        step_down,
  output logic [N_FIELDS*VAL_W-1:0]   field_vals,
  output logic [IDX_W-1:0]            focus,
  output logic                        update,
  output logic [IDX_W-1:0]            update_field
);

  logic [CODE_W-1:0] code_stable;
  logic              code_commit;
  logic              up_stable;
  logic              up_commit;
  logic              dn_stable;
  logic              dn_commit;

  debounce_sync #(.W(CODE_W), .CYCLES(DEBOUNCE)) u_code_db (
    .clk_48  (clk_48),
    .reset_n (reset_n),
    .raw_in  (code_in),
    .stable  (code_stable),
    .commit  (code_commit)
  );

  debounce_sync #(.W(1), .CYCLES(DEBOUNCE)) u_up_db (
    .clk_48  (clk_48),
    .reset_n (reset_n),
    .raw_in  (step_up),
    .stable  (up_stable),
    .commit  (up_commit)
  );

  debounce_sync #(.W(1), .CYCLES(DEBOUNCE)) u_dn_db (
    .clk_48  (clk_48),
    .reset_n (reset_n),
    .raw_in  (step_down),
    .stable  (dn_stable),
    .commit  (dn_commit)
  );

  logic [IDX_W-1:0] code_idx;
  logic [VAL_W-1:0] code_val;
  logic             code_valid;
  logic [VAL_W-1:0] code_old;
  logic [VAL_W-1:0] focus_val;
  logic [VAL_W-1:0] step_val;
  step_dir_e        step_dir;

  assign code_idx  = code_stable[CODE_W-1:VAL_W];
  assign code_val  = code_stable[VAL_W-1:0];
  // Widened by one bit so the compare stays meaningful for any N_FIELDS.
  assign code_valid = ({1'b0, code_idx} < (IDX_W + 1)'(N_FIELDS));
  assign code_old  = field_vals[code_idx*VAL_W +: VAL_W];
  assign focus_val = field_vals[focus*VAL_W +: VAL_W];

  // A step only happens on a debounced rising edge; commits of both
  // buttons in the same cycle cancel each other.
  always_comb begin
    step_dir = STEP_NONE;
    if (up_commit && !dn_commit && up_stable) begin
      step_dir = STEP_INC;
    end else if (dn_commit && !up_commit && dn_stable) begin
      step_dir = STEP_DEC;
    end
  end

  // Saturating or wrapping step of the focused field.
  always_comb begin
    step_val = focus_val;
    case (step_dir)
      STEP_INC: begin
        if ((focus_val != '1) || (WRAP != 0)) begin
          step_val = focus_val + VAL_W'(1);
        end
      end
      STEP_DEC: begin
        if ((focus_val != '0) || (WRAP != 0)) begin
          step_val = focus_val - VAL_W'(1);
        end
      end
      default: ;
    endcase
  end

  // A code commit takes priority and discards any step in the same cycle.
  // update only fires on a real value change, so focus can move silently.
  always_ff @(posedge clk_48 or negedge reset_n) begin
    if (!reset_n) begin
      field_vals   <= RESET_VALS;
      focus        <= '0;
      update       <= 1'b0;
      update_field <= '0;
    end else begin
      update <= 1'b0;
      if (code_commit) begin
        if (code_valid) begin
          focus <= code_idx;
          if (code_old != code_val) begin
            field_vals[code_idx*VAL_W +: VAL_W] <= code_val;
            update                              <= 1'b1;
            update_field                        <= code_idx;
          end
        end
      end else if ((step_dir != STEP_NONE) && (step_val != focus_val)) begin
        field_vals[focus*VAL_W +: VAL_W] <= step_val;
        update                           <= 1'b1;
        update_field                     <= focus;
      end
    end
  end

endmodule

// File: tb/tb_button_select_ctrl.sv
// Self-checking bench for button_select_ctrl (DEBOUNCE=4, other defaults).
// A reference model accepts an input once the last DEBOUNCE+1 values seen
// two cycles earlier agree and differ from the accepted one; it applies the
// field rules one cycle later and queues every expected update. A monitor on
// the falling edge compares outputs and pops the queue on each update pulse.
module tb_button_select_ctrl;

  localparam int NF   = 4;
  localparam int VW   = 3;
  localparam int IW   = 2;
  localparam int CW   = IW + VW;
  localparam int D    = 4;
  localparam int WRAP = 0;
  localparam int HIST = D + 3;
  localparam int VMAX = (1 << VW) - 1;
  localparam logic [NF*VW-1:0] RESET_PACKED = 12'h08C;

  logic             clk_48 = 1'b0;
  logic             reset_n = 1'b0;
  logic [CW-1:0]    code_in = '0;
  logic             step_up = 1'b0;
  logic             step_down = 1'b0;
  logic [NF*VW-1:0] field_vals;
  logic [IW-1:0]    focus;
  logic             update;
  logic [IW-1:0]    update_field;

  always #5 clk_48 = ~clk_48;

  button_select_ctrl #(
    .N_FIELDS (NF),
    .VAL_W    (VW),
    .DEBOUNCE (D),
    .WRAP     (WRAP)
  ) dut (
    .clk_48       (clk_48),
    .reset_n      (reset_n),
    .code_in      (code_in),
    .step_up      (step_up),
    .step_down    (step_down),
    .field_vals   (field_vals),
    .focus        (focus),
    .update       (update),
    .update_field (update_field)
  );

  int n_vec  = 0;
  int n_fail = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_vec++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [CW-1:0] c, input logic u, input logic d,
                               input int cycles);
    code_in   = c;
    step_up   = u;
    step_down = d;
    repeat (cycles) @(posedge clk_48);
    #1;
  endtask

  // Reference model state
  typedef struct {
    int fld;
    int val;
  } exp_t;

  exp_t          sb[$];
  exp_t          popped;
  logic [CW-1:0] h_code[HIST];
  logic          h_up[HIST];
  logic          h_dn[HIST];
  logic [CW-1:0] m_st_code;
  logic          m_st_up;
  logic          m_st_dn;
  int            m_vals[NF];
  int            m_focus;
  logic          m_update;
  logic          p_code_commit;
  logic [CW-1:0] p_code;
  int            p_step;
  int            t_idx, t_val, t_new;
  logic          ok_c, ok_u, ok_d, com_c, com_u, com_d;

  function automatic logic [NF*VW-1:0] packVals();
    logic [NF*VW-1:0] r;
    r = '0;
    for (int i = 0; i < NF; i++) r[i*VW +: VW] = VW'(m_vals[i]);
    return r;
  endfunction

  always @(posedge clk_48 or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < HIST; i++) begin
        h_code[i] = '0;
        h_up[i]   = 1'b0;
        h_dn[i]   = 1'b0;
      end
      m_st_code     = '0;
      m_st_up       = 1'b0;
      m_st_dn       = 1'b0;
      m_vals        = '{4, 1, 2, 0};
      m_focus       = 0;
      m_update      = 1'b0;
      p_code_commit = 1'b0;
      p_code        = '0;
      p_step        = 0;
      sb.delete();
    end else begin
      // Effects of last cycle's acceptances appear on the outputs now.
      m_update = 1'b0;
      if (p_code_commit) begin
        t_idx = int'(p_code) / (VMAX + 1);
        t_val = int'(p_code) % (VMAX + 1);
        if (t_idx < NF) begin
          m_focus = t_idx;
          if (m_vals[t_idx] != t_val) begin
            m_vals[t_idx] = t_val;
            m_update = 1'b1;
            sb.push_back('{t_idx, t_val});
          end
        end
      end else if (p_step != 0) begin
        t_new = m_vals[m_focus] + p_step;
        if (WRAP != 0) t_new = (t_new + VMAX + 1) % (VMAX + 1);
        else if (t_new < 0) t_new = 0;
        else if (t_new > VMAX) t_new = VMAX;
        if (t_new != m_vals[m_focus]) begin
          m_vals[m_focus] = t_new;
          m_update = 1'b1;
          sb.push_back('{m_focus, t_new});
        end
      end
      for (int i = HIST - 1; i > 0; i--) begin
        h_code[i] = h_code[i-1];
        h_up[i]   = h_up[i-1];
        h_dn[i]   = h_dn[i-1];
      end
      h_code[0] = code_in;
      h_up[0]   = step_up;
      h_dn[0]   = step_down;
      ok_c = 1'b1;
      ok_u = 1'b1;
      ok_d = 1'b1;
      for (int i = 3; i <= D + 2; i++) begin
        if (h_code[i] != h_code[2]) ok_c = 1'b0;
        if (h_up[i] != h_up[2]) ok_u = 1'b0;
        if (h_dn[i] != h_dn[2]) ok_d = 1'b0;
      end
      com_c = ok_c && (h_code[2] != m_st_code);
      com_u = ok_u && (h_up[2] != m_st_up);
      com_d = ok_d && (h_dn[2] != m_st_dn);
      if (com_c) m_st_code = h_code[2];
      if (com_u) m_st_up = h_up[2];
      if (com_d) m_st_dn = h_dn[2];
      p_code_commit = com_c;
      p_code        = m_st_code;
      p_step        = 0;
      if (!com_c && (com_u != com_d)) begin
        if (com_u && m_st_up) p_step = 1;
        else if (com_d && m_st_dn) p_step = -1;
      end
    end
  end

  // Monitor
  always @(negedge clk_48) begin
    checkOutput("field_vals", 32'(field_vals), 32'(packVals()));
    checkOutput("focus", 32'(focus), 32'(m_focus));
    checkOutput("update", 32'(update), 32'(m_update));
    if (update === 1'b1) begin
      if (sb.size() == 0) begin
        checkOutput("update_unexpected", 32'(update), 32'd0);
      end else begin
        popped = sb.pop_front();
        checkOutput("update_field", 32'(update_field), 32'(popped.fld));
        checkOutput("update_value", 32'(field_vals[popped.fld*VW +: VW]), 32'(popped.val));
      end
    end
  end

  logic [CW-1:0] cur_code;
  logic          cur_up;
  logic          cur_dn;

  initial begin
    repeat (3) @(posedge clk_48);
    #1;
    checkOutput("reset_vals", 32'(field_vals), 32'(RESET_PACKED));
    checkOutput("reset_focus", 32'(focus), 32'd0);
    checkOutput("reset_update", 32'(update), 32'd0);
    reset_n = 1'b1;

    // Latency of a code commit: first sampled at N0, visible at N0+7.
    code_in = 5'b01_010;
    repeat (7) @(posedge clk_48);
    #1;
    checkOutput("latency_early", 32'(update), 32'd0);
    @(posedge clk_48);
    #1;
    checkOutput("latency_update", 32'(update), 32'd1);
    checkOutput("latency_ufield", 32'(update_field), 32'd1);
    checkOutput("latency_field1", 32'(field_vals[5:3]), 32'd2);
    checkOutput("latency_focus", 32'(focus), 32'd1);
    applyStimulus(5'b01_010, 1'b0, 1'b0, 4);
    checkOutput("held_no_pulse", 32'(update), 32'd0);

    // Step into saturation, then a real decrement.
    applyStimulus(5'b01_111, 1'b0, 1'b0, 8);
    checkOutput("field1_seven", 32'(field_vals[5:3]), 32'd7);
    applyStimulus(5'b01_111, 1'b1, 1'b0, 6);
    applyStimulus(5'b01_111, 1'b0, 1'b0, 8);
    checkOutput("sat_field1", 32'(field_vals[5:3]), 32'd7);
    applyStimulus(5'b01_111, 1'b0, 1'b1, 8);
    applyStimulus(5'b01_111, 1'b0, 1'b0, 8);
    checkOutput("dec_field1", 32'(field_vals[5:3]), 32'd6);

    // Code and step_down accepted together: code wins.
    applyStimulus(5'b10_101, 1'b0, 1'b1, 8);
    applyStimulus(5'b10_101, 1'b0, 1'b0, 8);
    checkOutput("simul_field2", 32'(field_vals[8:6]), 32'd5);
    checkOutput("simul_focus", 32'(focus), 32'd2);
    checkOutput("simul_field1", 32'(field_vals[5:3]), 32'd6);

    // Short glitch never commits.
    applyStimulus(5'b10_011, 1'b0, 1'b0, 3);
    applyStimulus(5'b10_101, 1'b0, 1'b0, 10);
    checkOutput("glitch_field2", 32'(field_vals[8:6]), 32'd5);

    // Reset mid-debounce of a zero code: nothing commits afterwards.
    applyStimulus(5'b00_000, 1'b0, 1'b0, 3);
    reset_n = 1'b0;
    applyStimulus(5'b00_000, 1'b0, 1'b0, 2);
    checkOutput("midrst_vals", 32'(field_vals), 32'(RESET_PACKED));
    reset_n = 1'b1;
    applyStimulus(5'b00_000, 1'b0, 1'b0, 12);
    checkOutput("post_rst_vals", 32'(field_vals), 32'(RESET_PACKED));
    checkOutput("post_rst_focus", 32'(focus), 32'd0);

    // Randomised segments.
    cur_code = '0;
    cur_up   = 1'b0;
    cur_dn   = 1'b0;
    for (int s = 0; s < 120; s++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4: cur_code = CW'($urandom_range(0, (1 << CW) - 1));
        5, 6:          cur_up = ~cur_up;
        7, 8:          cur_dn = ~cur_dn;
        default: begin
          cur_up = ~cur_up;
          cur_dn = ~cur_dn;
        end
      endcase
      if ($urandom_range(0, 39) == 0) begin
        reset_n = 1'b0;
        applyStimulus(cur_code, cur_up, cur_dn, 2);
        reset_n = 1'b1;
      end
      applyStimulus(cur_code, cur_up, cur_dn, int'($urandom_range(1, 9)));
    end

    applyStimulus(cur_code, 1'b0, 1'b0, 16);
    checkOutput("queue_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/button_select_ctrl.md
Name: button_select_ctrl

Overview:
Parametrised successor to the front-panel button encoder. Converts raw panel button codes and up/down step buttons into N independent selection fields (band frequency, LPF/HPF corner, etc.) that drive the filter coefficient muxes. Adds input synchronisation, debouncing, edge-based commits, focus tracking, step up/down with saturate/wrap, and an update strobe for downstream coefficient reload. Sits between the panel GPIO pins and the filter-bank select inputs, in the clk_48 domain.

Parameters:
N_FIELDS, 4, number of selection fields (>=2)
VAL_W, 3, width of each field value
DEBOUNCE, 480, cycles an input must stay stable before it is accepted (>=2)
WRAP, 0, 0 = step saturates at 0 / 2^VAL_W-1; 1 = step wraps
RESET_VALS, {3'd0,3'd2,3'd1,3'd4}, packed per-field reset values, field 0 in LSBs
(derived) IDX_W = max(1, clog2(N_FIELDS)); CODE_W = IDX_W+VAL_W

Ports:
clk_48  in  1  system clock
reset_n  in  1  reset
code_in  in  CODE_W  raw button code {field index, value}; asynchronous to clk_48
step_up  in  1  raw increment button, active-high, asynchronous
step_down  in  1  raw decrement button, active-high, asynchronous
field_vals  out  N_FIELDS*VAL_W  current field values, field i at [i*VAL_W +: VAL_W]
focus  out  IDX_W  index of the field last written by code_in
update  out  1  one-cycle pulse when any field value changes
update_field  out  IDX_W  index of the changed field, valid while update=1

Behaviour:
- Reset: reset_n is asynchronous, active-low; clock is clk_48. On reset: field_vals=RESET_VALS, focus=0, update=0, update_field=0. All sync, candidate, stable and counter registers clear to 0.
- Sync: two-flop synchroniser on code_in, step_up and step_down.
- Debounce, per group (code, up, down):
  - If synced != candidate: candidate<=synced, counter<=0.
  - Else, if counter<DEBOUNCE-1: counter++.
  - When counter==DEBOUNCE-1 and candidate!=stable: stable<=candidate and a registered commit pulse is raised.
  - A glitch shorter than DEBOUNCE cycles restarts the counter and never commits.
- Latency: a new input first sampled at edge N0 changes field_vals at edge N0+2+DEBOUNCE+1. update asserts in that same cycle.
- Code commit: triggered only by a change of the debounced code; a held code commits once.
  - idx=code[CODE_W-1:VAL_W], val=code[VAL_W-1:0].
  - If idx<N_FIELDS: field[idx]<=val, focus<=idx.
  - If idx>=N_FIELDS: ignored, focus unchanged.
  - The debounced code resets to 0, so a code of 0 held through reset does not commit.
- Step: a debounced rising edge of step_up (or step_down) adds (or subtracts) 1 on field[focus].
  - WRAP=0: saturate at the limit.
  - WRAP=1: modulo 2^VAL_W.
  - Falling edges do nothing.
- Simultaneous events:
  - Up and down commits in the same cycle cancel: no change.
  - A code commit in the same cycle as a step commit: the code commit wins and the step is discarded.
- update fires only when the written value differs from the old one. Rewriting the same value or stepping into saturation gives no pulse. focus may still change with no update.
- Reset asserted mid-debounce discards any pending commit.

Decomposition:
- Package button_select_pkg: default parameter constants (DEBOUNCE_DEFAULT, RESET_VALS_DEFAULT) and a field-index typedef helper.
- One sub-module, debounce_sync #(W, CYCLES): 2-flop sync + candidate/counter/stable logic, outputs stable[W] and a commit pulse. Instantiated three times (W=CODE_W, 1, 1).

Test Plan:
- Sims use DEBOUNCE=4 and default parameters.
- Reset -> field_vals fields {0:4, 1:1, 2:2, 3:0}, focus=0, update=0.
- code_in=5'b01_010 (field1=2) held from edge N0 -> field1=2, focus=1, update=1 for exactly one cycle with update_field=1 at edge N0+7; no further pulse while held.
- code_in toggled 5'b10_011 for 3 cycles, then back to its previous value -> no commit, field2 unchanged.
- focus=1, field1=7; step_up pulse held 6 cycles -> WRAP=0: field1 stays 7, no update; WRAP=1: field1=0, update=1.
- code_in change and step_down reach commit on the same cycle -> code value written; step ignored (field not decremented).
- reset_n pulsed low 3 cycles after a code change -> all outputs return to reset values, and no commit occurs afterwards for that code until it changes again.
